// File: rtl/cgb_pixel_writer_if.sv
// Pixel-in / framebuffer-out bundle for cgb_pixel_writer.
// The master side is the writer itself; the slave side is the pixel source and framebuffer.
interface cgb_pixel_writer_if;
    logic        pix_valid;
    logic [14:0] pix_color;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [23:0] fb_wdata;
    logic        fb_ready;

    modport master (
        input  pix_valid, pix_color, fb_ready,
        output fb_we, fb_addr, fb_wdata
    );

    modport slave (
        output pix_valid, pix_color, fb_ready,
        input  fb_we, fb_addr, fb_wdata
    );
endinterface

// File: rtl/cgb_pixel_writer.sv
// CGB LCD pixel stream to RGB888 framebuffer writer.
// A 4-deep FIFO absorbs framebuffer backpressure. Pixels that arrive while it is full are dropped.
module cgb_pixel_writer (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_en,
    input  logic                      frame_start,
    cgb_pixel_writer_if.master        pif,
    output logic                      frame_done,
    output logic                      overflow,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    localparam logic [14:0] LAST_IDX = 15'd23039;

    state_t      state_q, state_d;
    logic [14:0] idx_q, idx_d;
    logic [29:0] mem_q [4];
    logic [29:0] mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        frame_done_q, frame_done_d;

    logic        qual, push, pop, drop;
    logic [29:0] head;

    function automatic logic [23:0] rgb888(input logic [14:0] c);
        return {c[4:0], c[4:2], c[9:5], c[9:7], c[14:10], c[14:12]};
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;

        pop  = (count_q != 3'd0) && pif.fb_ready;
        // A frame_start cycle flushes everything, so a pixel presented with it is ignored.
        qual = cpu_en && pif.pix_valid && (state_q == ACTIVE) && !frame_start;
        push = qual && ((count_q != 3'd4) || pop);
        drop = qual && !push;

        if (push) begin
            mem_d[wr_ptr_q] = {idx_q, pif.pix_color};
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
        if (drop) overflow_d = 1'b1;
        if (qual) idx_d = idx_q + 15'd1;

        count_d = count_q + {2'b00, push} - {2'b00, pop};

        case (state_q)
            IDLE: idx_d = 15'd0;
            ACTIVE: begin
                if (qual && (idx_q == LAST_IDX)) begin
                    state_d = DRAIN;
                    idx_d   = 15'd0;
                end
            end
            DRAIN: begin
                if (count_d == 3'd0) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_start) begin
            state_d      = ACTIVE;
            idx_d        = 15'd0;
            wr_ptr_d     = 2'd0;
            rd_ptr_d     = 2'd0;
            count_d      = 3'd0;
            overflow_d   = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 15'd0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head         = mem_q[rd_ptr_q];
    assign pif.fb_we    = (count_q != 3'd0);
    assign pif.fb_addr  = pif.fb_we ? head[29:15] : 15'd0;
    assign pif.fb_wdata = pif.fb_we ? rgb888(head[14:0]) : 24'd0;
    assign frame_done   = frame_done_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_cgb_pixel_writer.sv
// Scoreboard bench for cgb_pixel_writer: stimulus queues expected writes, a monitor checks them.
module tb_cgb_pixel_writer;
    logic clk = 1'b0;
    logic reset, cpu_en, frame_start;
    logic frame_done, overflow, busy;

    cgb_pixel_writer_if pif ();

    cgb_pixel_writer dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_en      (cpu_en),
        .frame_start (frame_start),
        .pif         (pif.master),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] a;
        logic [23:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fd_cnt = 0;

    function automatic logic [23:0] exp888(input logic [14:0] c);
        return {c[4:0], c[4:2], c[9:5], c[9:7], c[14:10], c[14:12]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // The monitor samples on the falling edge, so a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) fd_cnt++;
            if (pif.fb_we && pif.fb_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %06h, none expected",
                             pif.fb_addr, pif.fb_wdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (pif.fb_addr !== e.a || pif.fb_wdata !== e.d) begin
                        errors++;
                        $display("FAIL write: got addr %0d data %06h expected addr %0d data %06h",
                                 pif.fb_addr, pif.fb_wdata, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic en, input logic [14:0] c, input bit exp_push,
                       input logic [14:0] a, input logic [23:0] d);
        pif.pix_valid = 1'b1;
        cpu_en        = en;
        pif.pix_color = c;
        if (exp_push) exp_q.push_back('{a: a, d: d});
        tick(1);
        pif.pix_valid = 1'b0;
        cpu_en        = 1'b1;
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 100) begin
            tick(1);
            k++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [14:0] dc [4];
        logic [23:0] dd [4];
        int fd0;
        dc = '{15'h7FFF, 15'h001F, 15'h7C00, 15'h0421};
        dd = '{24'hFFFFFF, 24'hFF0000, 24'h0000FF, 24'h080808};

        reset = 1'b1; cpu_en = 1'b1; frame_start = 1'b0;
        pif.pix_valid = 1'b0; pif.pix_color = 15'd0; pif.fb_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("rst_fb_we", {31'd0, pif.fb_we}, 0);
        chk("rst_fb_addr", {17'd0, pif.fb_addr}, 0);
        chk("rst_fb_wdata", {8'd0, pif.fb_wdata}, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_busy", {31'd0, busy}, 0);

        // Pixels in IDLE must be ignored; the monitor flags any write.
        for (int i = 0; i < 3; i++) pix(1'b1, 15'h1111, 0, 0, 0);
        tick(2);
        chk("idle_no_we", {31'd0, pif.fb_we}, 0);
        chk("idle_busy", {31'd0, busy}, 0);

        // Full frame with the framebuffer always ready, plus gated cycles that must not advance the index.
        fstart();
        chk("frame_busy", {31'd0, busy}, 1);
        for (int i = 0; i < 23040; i++) begin
            if (i == 10 || i == 5000) pix(1'b0, 15'h2AAA, 0, 0, 0);
            if (i < 4) pix(1'b1, dc[i], 1, 15'(i), dd[i]);
            else       pix(1'b1, 15'(i), 1, 15'(i), exp888(15'(i)));
        end
        wait_idle("frame_idle");
        tick(2);
        chk("frame_done_cnt", fd_cnt, 1);
        chk("frame_overflow", {31'd0, overflow}, 0);
        chk("frame_q_empty", exp_q.size(), 0);

        // Backpressure: 4 buffered, 2 dropped, next index is 6.
        pif.fb_ready = 1'b0;
        fstart();
        for (int i = 0; i < 6; i++) pix(1'b1, 15'h0421, i < 4, 15'(i), 24'h080808);
        chk("bp_overflow", {31'd0, overflow}, 1);
        chk("bp_we_held", {31'd0, pif.fb_we}, 1);
        chk("bp_addr_held", {17'd0, pif.fb_addr}, 0);
        pif.fb_ready = 1'b1;
        tick(6);
        pix(1'b1, 15'h001F, 1, 15'd6, 24'hFF0000);
        tick(2);
        chk("bp_overflow_sticky", {31'd0, overflow}, 1);
        chk("bp_q_empty", exp_q.size(), 0);

        // Full FIFO with a simultaneous pop accepts the pixel.
        pif.fb_ready = 1'b0;
        fstart();
        chk("fp_overflow_cleared", {31'd0, overflow}, 0);
        for (int i = 0; i < 4; i++) pix(1'b1, 15'h7C00, 1, 15'(i), 24'h0000FF);
        pif.fb_ready = 1'b1;
        pix(1'b1, 15'h7FFF, 1, 15'd4, 24'hFFFFFF);
        chk("fp_overflow", {31'd0, overflow}, 0);
        tick(6);
        chk("fp_q_empty", exp_q.size(), 0);

        // Abort mid-frame with 3 pixels buffered.
        fstart();
        for (int i = 0; i < 97; i++) pix(1'b1, 15'(i), 1, 15'(i), exp888(15'(i)));
        tick(1);
        pif.fb_ready = 1'b0;
        for (int i = 97; i < 100; i++) pix(1'b1, 15'(i), 0, 0, 0);
        fd0 = fd_cnt;
        fstart();
        pif.fb_ready = 1'b1;
        tick(1);
        chk("abort_flushed", {31'd0, pif.fb_we}, 0);
        pix(1'b1, 15'h0421, 1, 15'd0, 24'h080808);
        tick(3);
        chk("abort_no_done", fd_cnt, fd0);
        chk("abort_q_empty", exp_q.size(), 0);

        // Reset while draining: run a frame under full backpressure, then reset.
        pif.fb_ready = 1'b0;
        fstart();
        pif.pix_valid = 1'b1;
        pif.pix_color = 15'h1234;
        tick(23040);
        pif.pix_valid = 1'b0;
        chk("drain_busy", {31'd0, busy}, 1);
        chk("drain_overflow", {31'd0, overflow}, 1);
        fd0 = fd_cnt;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        pif.fb_ready = 1'b1;
        chk("drain_rst_we", {31'd0, pif.fb_we}, 0);
        chk("drain_rst_busy", {31'd0, busy}, 0);
        chk("drain_rst_overflow", {31'd0, overflow}, 0);
        tick(4);
        chk("drain_rst_no_done", fd_cnt, fd0);
        chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cgb_pixel_writer.md
CGB_PIXEL_WRITER -- requirements
Module: cgb_pixel_writer

Interface
REQ-001 SHALL have `clk`, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have `cpu_en`, input, 1 bit: clock enable qualifying the pixel-input side only.
REQ-004 SHALL have `frame_start`, input, 1 bit: one-cycle pulse, start of frame (end of VBlank); not gated by `cpu_en`.
REQ-005 SHALL have `pix_valid`, input, 1 bit: a pixel is presented this cycle.
REQ-006 SHALL have `pix_color`, input, 15 bits: CGB colour, R=[4:0], G=[9:5], B=[14:10].
REQ-007 SHALL have `fb_we`, output, 1 bit: framebuffer write request.
REQ-008 SHALL have `fb_addr`, output, 15 bits: linear pixel index, y*160+x.
REQ-009 SHALL have `fb_wdata`, output, 24 bits: RGB888 as {R8,G8,B8}.
REQ-010 SHALL have `fb_ready`, input, 1 bit: framebuffer accepts the write this cycle.
REQ-011 SHALL have `frame_done`, output, 1 bit: one-cycle pulse when the last pixel of a frame has been written.
REQ-012 SHALL have `overflow`, output, 1 bit: sticky flag, set when a pixel was dropped this frame.
REQ-013 SHALL have `busy`, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ACTIVE and DRAIN.
REQ-015 SHALL move IDLE->ACTIVE on `frame_start`.
REQ-016 SHALL move ACTIVE->DRAIN when pixel index 23039 is accepted or dropped.
REQ-017 SHALL move DRAIN->IDLE on the cycle the FIFO becomes empty, pulsing `frame_done` on that same transition.
REQ-018 SHALL, on `frame_start` in ACTIVE or DRAIN, flush the FIFO, zero the index, clear `overflow`, enter ACTIVE, and suppress `frame_done`.
REQ-019 SHALL keep a 15-bit input pixel index (0..23039), advancing by one per qualified pixel (`cpu_en & pix_valid` in ACTIVE), whether the pixel is pushed or dropped.
REQ-020 SHALL ignore pixels in IDLE and DRAIN: no index change and no overflow.
REQ-021 SHALL hold the pixel index at 0 while in IDLE.
REQ-022 SHALL use a 4-entry FIFO with entries {index[14:0], colour[14:0]}.
REQ-023 SHALL push a qualified pixel if count<4, or if count==4 and a pop occurs in the same cycle.
REQ-024 SHALL otherwise drop the pixel and set `overflow`.
REQ-025 SHALL drive `fb_we` = FIFO not empty, with `fb_addr` and `fb_wdata` taken combinationally from the head entry.
REQ-026 SHALL pop on `fb_we & fb_ready`, independent of `cpu_en`.
REQ-027 SHALL hold `fb_addr` and `fb_wdata` stable while `fb_we=1` and `fb_ready=0`.
REQ-028 SHALL expand each 5-bit channel c to 8 bits as {c, c[4:2]}, so 00000->0x00 and 11111->0xFF.
REQ-029 SHALL give a minimum latency of 1 cycle: a pixel pushed into an empty FIFO at edge N appears on `fb_we` after edge N.
REQ-030 SHALL update the FIFO count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-031 SHALL wrap FIFO pointers modulo 4.

Reset
REQ-032 SHALL, on `reset`, set: state IDLE, FIFO empty, index 0, `fb_we=0`, `fb_addr=0`, `fb_wdata=0`, `frame_done=0`, `overflow=0`, `busy=0`.
REQ-033 SHALL give `reset` priority over `frame_start` and all other inputs.
REQ-034 SHALL, on `reset` mid-frame, discard buffered pixels without writing them.

Verification
REQ-035 Frame, `fb_ready` held 1: `frame_start`, then 23040 pixels with `cpu_en=1` -> 23040 writes with addresses 0..23039 in order, exactly one `frame_done`, `overflow=0`, `busy=0` afterwards.
REQ-036 Colour expansion: `pix_color`=0x7FFF -> `fb_wdata`=0xFFFFFF; 0x001F -> 0xFF0000; 0x7C00 -> 0x0000FF; 0x0421 -> 0x080808.
REQ-037 Backpressure: `fb_ready=0` while 6 pixels are sent -> indices 0..3 buffered, 4 and 5 dropped, `overflow=1`; after `fb_ready=1`, writes occur to addresses 0,1,2,3 only, and the next pixel gets address 6.
REQ-038 Full with simultaneous pop: count=4 and `fb_ready=1` during a push -> pixel accepted, count stays 4, `overflow` unchanged.
REQ-039 Abort: `frame_start` after 100 pixels with 3 buffered -> no writes to addresses 97..99, next pixel written to address 0, no `frame_done`.
REQ-040 Gating: `pix_valid=1` with `cpu_en=0`, and any pixel in IDLE -> no push and index unchanged; `reset` mid-DRAIN -> `fb_we=0` next cycle and no `frame_done`.
